// File: rtl/prbs_pkg.sv
// Shared PRBS link-test definitions: phase encoding, preamble and PRBS-7 polynomial/seed.
// Also used by the receive-side pattern detector and the PRBS checker.
package prbs_pkg;

  typedef enum logic [1:0] {
    PhIdle     = 2'd0,
    PhPreamble = 2'd1,
    PhPrbs     = 2'd2,
    PhDone     = 2'd3
  } prbs_phase_e;

  localparam logic [31:0] PREAMBLE_DEFAULT = 32'h10ABCDEF;

  // x^7 + x^6 + 1
  localparam int unsigned PRBS7_TAP_HI = 6;
  localparam int unsigned PRBS7_TAP_LO = 5;
  localparam logic [6:0]  PRBS7_SEED_DEFAULT = 7'h7F;

  function automatic logic [6:0] prbs7_step(input logic [6:0] s);
    return {s[5:0], s[PRBS7_TAP_HI] ^ s[PRBS7_TAP_LO]};
  endfunction

endpackage

// File: rtl/prbs7_byte_lfsr.sv
// PRBS-7 state register emitting one byte (MSB = first bit) per advance, 8 steps unrolled.
// With load set, the byte and next state are taken from the seed instead of the register.
module prbs7_byte_lfsr
  import prbs_pkg::*;
#(
  parameter logic [6:0] RESET_SEED = PRBS7_SEED_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [6:0] seed,
  input  logic       advance,
  output logic [7:0] data
);

  logic [6:0] state_q, state_d;
  logic [6:0] src;
  logic [6:0] walk;

  always_comb begin
    src  = load ? seed : state_q;
    walk = src;
    data = 8'h00;
    for (int i = 0; i < 8; i++) begin
      data[7-i] = walk[6];
      walk      = prbs7_step(walk);
    end
    state_d = advance ? walk : src;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RESET_SEED;
    end else begin
      state_q <= state_d;
    end
  end

endmodule

// File: rtl/prbs_tx_sequencer.sv
// PRBS link-test transmitter: N_PATTERN preambles then N_PRBS PRBS-7 bytes over valid/ready.
// Optional macro PRBS_ERR_INJECT_EN adds ERR_INJECT to flip bit 0 of the next PRBS byte.
module prbs_tx_sequencer
  import prbs_pkg::*;
#(
  parameter logic [31:0] PREAMBLE  = PREAMBLE_DEFAULT,
  parameter logic [6:0]  LFSR_SEED = PRBS7_SEED_DEFAULT
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        START,
  input  logic        ABORT,
  input  logic [7:0]  N_PATTERN,
  input  logic [15:0] N_PRBS,
`ifdef PRBS_ERR_INJECT_EN
  input  logic        ERR_INJECT,
`endif
  output logic [7:0]  OUT_DATA,
  output logic        OUT_VALID,
  input  logic        OUT_READY,
  output logic        BUSY,
  output logic        DONE,
  output logic [1:0]  PHASE
);

  localparam logic [1:0] ST_IDLE     = PhIdle;
  localparam logic [1:0] ST_PREAMBLE = PhPreamble;
  localparam logic [1:0] ST_PRBS     = PhPrbs;
  localparam logic [1:0] ST_DONE     = PhDone;

  logic [1:0]  state_q, state_d;
  logic [7:0]  out_data_q, out_data_d;
  logic        out_valid_q, out_valid_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [1:0]  byte_idx_q, byte_idx_d;
  logic [7:0]  rep_q, rep_d;
  logic [15:0] prbs_cnt_q, prbs_cnt_d;
  logic [7:0]  n_pattern_q, n_pattern_d;
  logic [15:0] n_prbs_q, n_prbs_d;

  logic        xfer;
  logic        go_prbs, go_done;
  logic        lfsr_load, lfsr_advance;
  logic [7:0]  lfsr_data;

  assign xfer = out_valid_q && OUT_READY;

  function automatic logic [7:0] preamble_byte(input logic [1:0] idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = PREAMBLE[31:24];
      2'd1:    b = PREAMBLE[23:16];
      2'd2:    b = PREAMBLE[15:8];
      default: b = PREAMBLE[7:0];
    endcase
    return b;
  endfunction

  prbs7_byte_lfsr #(
    .RESET_SEED(LFSR_SEED)
  ) u_lfsr (
    .clk    (CLK),
    .rst_n  (RST),
    .load   (lfsr_load),
    .seed   (LFSR_SEED),
    .advance(lfsr_advance),
    .data   (lfsr_data)
  );

  always_comb begin
    state_d      = state_q;
    out_data_d   = out_data_q;
    out_valid_d  = out_valid_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    byte_idx_d   = byte_idx_q;
    rep_d        = rep_q;
    prbs_cnt_d   = prbs_cnt_q;
    n_pattern_d  = n_pattern_q;
    n_prbs_d     = n_prbs_q;
    lfsr_load    = 1'b0;
    lfsr_advance = 1'b0;
    go_prbs      = 1'b0;
    go_done      = 1'b0;

    // ABORT beats any same-edge transfer; in IDLE it also masks START.
    if (ABORT) begin
      if (state_q != ST_IDLE) begin
        state_d     = ST_IDLE;
        out_valid_d = 1'b0;
        busy_d      = 1'b0;
      end
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (START) begin
            n_pattern_d = N_PATTERN;
            n_prbs_d    = N_PRBS;
            byte_idx_d  = 2'd0;
            rep_d       = 8'd0;
            prbs_cnt_d  = 16'd0;
            lfsr_load   = 1'b1;
            busy_d      = 1'b1;
            if (N_PATTERN != 8'd0) begin
              state_d     = ST_PREAMBLE;
              out_data_d  = preamble_byte(2'd0);
              out_valid_d = 1'b1;
            end else if (N_PRBS != 16'd0) begin
              go_prbs = 1'b1;
            end else begin
              go_done = 1'b1;
            end
          end
        end
        ST_PREAMBLE: begin
          if (xfer) begin
            byte_idx_d = byte_idx_q + 2'd1;
            if (byte_idx_q == 2'd3) begin
              rep_d = rep_q + 8'd1;
              if (rep_q + 8'd1 == n_pattern_q) begin
                go_prbs = (n_prbs_q != 16'd0);
                go_done = (n_prbs_q == 16'd0);
              end else begin
                out_data_d = preamble_byte(2'd0);
              end
            end else begin
              out_data_d = preamble_byte(byte_idx_q + 2'd1);
            end
          end
        end
        ST_PRBS: begin
          if (xfer) begin
            prbs_cnt_d = prbs_cnt_q + 16'd1;
            if (prbs_cnt_q + 16'd1 == n_prbs_q) begin
              go_done = 1'b1;
            end else begin
              go_prbs = 1'b1;
            end
          end
        end
        default: begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end
      endcase
    end

    // The LFSR steps when a byte is loaded for presentation, so it always holds the next byte.
    if (go_prbs) begin
      state_d      = ST_PRBS;
      out_data_d   = lfsr_data;
      out_valid_d  = 1'b1;
      lfsr_advance = 1'b1;
    end
    if (go_done) begin
      state_d     = ST_DONE;
      out_valid_d = 1'b0;
      busy_d      = 1'b0;
      done_d      = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q     <= ST_IDLE;
      out_data_q  <= 8'h00;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      byte_idx_q  <= 2'd0;
      rep_q       <= 8'd0;
      prbs_cnt_q  <= 16'd0;
      n_pattern_q <= 8'd0;
      n_prbs_q    <= 16'd0;
    end else begin
      state_q     <= state_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      byte_idx_q  <= byte_idx_d;
      rep_q       <= rep_d;
      prbs_cnt_q  <= prbs_cnt_d;
      n_pattern_q <= n_pattern_d;
      n_prbs_q    <= n_prbs_d;
    end
  end

`ifdef PRBS_ERR_INJECT_EN
  logic err_q, err_d;

  always_comb begin
    err_d = err_q | ERR_INJECT;
    if (state_q == ST_PRBS && xfer) begin
      err_d = ERR_INJECT;
    end
    if ((ABORT && state_q != ST_IDLE) || state_q == ST_DONE) begin
      err_d = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  // Corruption is applied at the output so the LFSR sequence itself stays clean.
  assign OUT_DATA = out_data_q ^ {7'd0, err_q && (state_q == ST_PRBS)};
`else
  assign OUT_DATA = out_data_q;
`endif

  assign OUT_VALID = out_valid_q;
  assign BUSY      = busy_q;
  assign DONE      = done_q;
  assign PHASE     = state_q;

endmodule

// File: tb/tb_prbs_tx_sequencer.sv
// Directed bench for prbs_tx_sequencer; define PRBS_ERR_INJECT_EN to also cover error injection.
module tb_prbs_tx_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, abort, out_ready;
  logic [7:0]  n_pattern;
  logic [15:0] n_prbs;
  logic [7:0]  out_data;
  logic        out_valid, busy, done;
  logic [1:0]  phase;
`ifdef PRBS_ERR_INJECT_EN
  logic        err_inject;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  prbs_tx_sequencer dut (
    .CLK       (clk),
    .RST       (rst_n),
    .START     (start),
    .ABORT     (abort),
    .N_PATTERN (n_pattern),
    .N_PRBS    (n_prbs),
`ifdef PRBS_ERR_INJECT_EN
    .ERR_INJECT(err_inject),
`endif
    .OUT_DATA  (out_data),
    .OUT_VALID (out_valid),
    .OUT_READY (out_ready),
    .BUSY      (busy),
    .DONE      (done),
    .PHASE     (phase)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; out_ready = 1'b1;
    n_pattern = 8'd0; n_prbs = 16'd0;
`ifdef PRBS_ERR_INJECT_EN
    err_inject = 1'b0;
`endif
    #12;
    n_cmp++; if ({out_data, out_valid, busy, done, phase} !== 13'd0) begin
      n_err++; $display("FAIL reset_outputs: got %h want 0", {out_data, out_valid, busy, done, phase});
    end
    rst_n = 1'b1;
    tick;
    n_cmp++; if (phase !== 2'd0 || busy !== 1'b0) begin
      n_err++; $display("FAIL reset_idle: got phase=%0d busy=%b want 0/0", phase, busy);
    end
  endtask

  task automatic test_preamble_only;
    logic [7:0] exp_b [8];
    int busy_cycles;
    exp_b = '{8'h10, 8'hAB, 8'hCD, 8'hEF, 8'h10, 8'hAB, 8'hCD, 8'hEF};
    busy_cycles = 0;
    n_pattern = 8'd2; n_prbs = 16'd0; out_ready = 1'b1; start = 1'b1;
    tick;
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (busy) busy_cycles++;
      n_cmp++; if (out_valid !== 1'b1 || out_data !== exp_b[i] || phase !== 2'd1) begin
        n_err++; $display("FAIL pre_byte%0d: got v=%b d=%h ph=%0d want 1/%h/1", i, out_valid,
                          out_data, phase, exp_b[i]);
      end
      tick;
    end
    n_cmp++; if (done !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0 || phase !== 2'd3) begin
      n_err++; $display("FAIL pre_done: got d=%b b=%b v=%b ph=%0d want 1/0/0/3", done, busy,
                        out_valid, phase);
    end
    n_cmp++; if (busy_cycles !== 8) begin
      n_err++; $display("FAIL pre_busy_len: got %0d want 8", busy_cycles);
    end
    tick;
    n_cmp++; if (done !== 1'b0 || phase !== 2'd0) begin
      n_err++; $display("FAIL pre_after_done: got d=%b ph=%0d want 0/0", done, phase);
    end
  endtask

  task automatic test_prbs_only;
    logic [7:0] exp_b [4];
    exp_b = '{8'hFE, 8'h04, 8'h18, 8'h51};
    n_pattern = 8'd0; n_prbs = 16'd4; out_ready = 1'b1; start = 1'b1;
    tick;
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (out_valid !== 1'b1 || out_data !== exp_b[i] || phase !== 2'd2) begin
        n_err++; $display("FAIL prbs_byte%0d: got v=%b d=%h ph=%0d want 1/%h/2", i, out_valid,
                          out_data, phase, exp_b[i]);
      end
      tick;
    end
    n_cmp++; if (done !== 1'b1 || out_valid !== 1'b0) begin
      n_err++; $display("FAIL prbs_done: got d=%b v=%b want 1/0", done, out_valid);
    end
    tick;
  endtask

  task automatic test_stall;
    logic [7:0] exp_b [6];
    logic [7:0] prev_data;
    bit prev_stall, seen_done;
    int n;
    exp_b = '{8'h10, 8'hAB, 8'hCD, 8'hEF, 8'hFE, 8'h04};
    prev_data = 8'h00; prev_stall = 1'b0; seen_done = 1'b0; n = 0;
    n_pattern = 8'd1; n_prbs = 16'd2; out_ready = 1'b1; start = 1'b1;
    tick;
    start = 1'b0;
    for (int c = 0; c < 40 && !seen_done; c++) begin
      if (done) begin
        seen_done = 1'b1;
      end else begin
        out_ready = (c % 4 == 0) || (c % 4 == 3);
        n_cmp++; if (out_valid !== 1'b1) begin
          n_err++; $display("FAIL stall_bubble c%0d: got v=%b want 1", c, out_valid);
        end
        if (prev_stall) begin
          n_cmp++; if (out_data !== prev_data) begin
            n_err++; $display("FAIL stall_hold c%0d: got %h want %h", c, out_data, prev_data);
          end
        end
        if (out_valid && out_ready) begin
          if (n < 6) begin
            n_cmp++; if (out_data !== exp_b[n]) begin
              n_err++; $display("FAIL stall_xfer%0d: got %h want %h", n, out_data, exp_b[n]);
            end
          end
          n++;
        end
        prev_stall = out_valid && !out_ready;
        prev_data  = out_data;
        tick;
      end
    end
    out_ready = 1'b1;
    n_cmp++; if (!seen_done || n !== 6) begin
      n_err++; $display("FAIL stall_count: got done=%b xfers=%0d want 1/6", seen_done, n);
    end
    tick;
  endtask

  task automatic test_zero_and_busy_start;
    int xfers;
    bit seen_done;
    n_pattern = 8'd0; n_prbs = 16'd0; start = 1'b1;
    tick;
    start = 1'b0;
    n_cmp++; if (done !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || phase !== 2'd3) begin
      n_err++; $display("FAIL zero_done: got d=%b v=%b b=%b ph=%0d want 1/0/0/3", done,
                        out_valid, busy, phase);
    end
    tick;
    n_cmp++; if (done !== 1'b0 || out_valid !== 1'b0 || phase !== 2'd0) begin
      n_err++; $display("FAIL zero_after: got d=%b v=%b ph=%0d want 0/0/0", done, out_valid, phase);
    end
    n_pattern = 8'd1; n_prbs = 16'd0; start = 1'b1;
    tick;
    n_pattern = 8'd5; n_prbs = 16'd9;
    tick;
    start = 1'b0;
    xfers = 1; seen_done = 1'b0;
    for (int c = 0; c < 30 && !seen_done; c++) begin
      if (done) seen_done = 1'b1;
      else begin
        if (out_valid && out_ready) xfers++;
        tick;
      end
    end
    n_cmp++; if (!seen_done || xfers !== 4) begin
      n_err++; $display("FAIL busy_start: got done=%b xfers=%0d want 1/4", seen_done, xfers);
    end
    tick;
  endtask

  task automatic test_abort;
    n_pattern = 8'd0; n_prbs = 16'd4; out_ready = 1'b1; start = 1'b1;
    tick;
    start = 1'b0;
    tick;
    n_cmp++; if (out_data !== 8'h04) begin
      n_err++; $display("FAIL abort_pre: got %h want 04", out_data);
    end
    abort = 1'b1;
    tick;
    abort = 1'b0;
    n_cmp++; if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || phase !== 2'd0) begin
      n_err++; $display("FAIL abort_drop: got v=%b b=%b d=%b ph=%0d want 0/0/0/0", out_valid,
                        busy, done, phase);
    end
    for (int i = 0; i < 3; i++) begin
      tick;
      n_cmp++; if (done !== 1'b0) begin
        n_err++; $display("FAIL abort_no_done%0d: got %b want 0", i, done);
      end
    end
    n_pattern = 8'd1; start = 1'b1; abort = 1'b1;
    tick;
    start = 1'b0; abort = 1'b0;
    n_cmp++; if (busy !== 1'b0 || out_valid !== 1'b0 || phase !== 2'd0) begin
      n_err++; $display("FAIL start_abort_idle: got b=%b v=%b ph=%0d want 0/0/0", busy, out_valid,
                        phase);
    end
    start = 1'b1;
    tick;
    start = 1'b0;
    n_cmp++; if (out_data !== 8'h10 || out_valid !== 1'b1) begin
      n_err++; $display("FAIL restart_pre: got %h v=%b want 10/1", out_data, out_valid);
    end
    abort = 1'b1;
    tick;
    abort = 1'b0;
    n_pattern = 8'd0; n_prbs = 16'd1; start = 1'b1;
    tick;
    start = 1'b0;
    n_cmp++; if (out_data !== 8'hFE || out_valid !== 1'b1) begin
      n_err++; $display("FAIL restart_prbs: got %h v=%b want fe/1", out_data, out_valid);
    end
    tick;
    n_cmp++; if (done !== 1'b1) begin
      n_err++; $display("FAIL restart_done: got %b want 1", done);
    end
    tick;
  endtask

  task automatic test_async_reset;
    n_pattern = 8'd3; n_prbs = 16'd5; start = 1'b1;
    tick;
    start = 1'b0;
    tick;
    tick;
    #3;
    rst_n = 1'b0;
    #1;
    n_cmp++; if ({out_data, out_valid, busy, done, phase} !== 13'd0) begin
      n_err++; $display("FAIL async_reset: got %h want 0", {out_data, out_valid, busy, done, phase});
    end
    #3;
    rst_n = 1'b1;
    tick;
    n_cmp++; if (busy !== 1'b0 || done !== 1'b0 || out_valid !== 1'b0) begin
      n_err++; $display("FAIL post_reset: got b=%b d=%b v=%b want 0/0/0", busy, done, out_valid);
    end
  endtask

`ifdef PRBS_ERR_INJECT_EN
  task automatic test_err_inject;
    logic [7:0] exp_b [6];
    exp_b = '{8'h10, 8'hAB, 8'hCD, 8'hEF, 8'hFF, 8'h04};
    err_inject = 1'b1;
    tick;
    err_inject = 1'b0;
    n_pattern = 8'd0; n_prbs = 16'd1; start = 1'b1;
    tick;
    start = 1'b0;
    n_cmp++; if (out_data !== 8'hFF) begin
      n_err++; $display("FAIL inject_single: got %h want ff", out_data);
    end
    tick;
    tick;
    err_inject = 1'b1;
    tick;
    err_inject = 1'b0;
    n_pattern = 8'd1; n_prbs = 16'd2; start = 1'b1;
    tick;
    start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      n_cmp++; if (out_data !== exp_b[i]) begin
        n_err++; $display("FAIL inject_stream%0d: got %h want %h", i, out_data, exp_b[i]);
      end
      tick;
    end
    tick;
  endtask
`endif

  initial begin
    test_reset;
    test_preamble_only;
    test_prbs_only;
    test_stall;
    test_zero_and_busy_start;
    test_abort;
    test_async_reset;
`ifdef PRBS_ERR_INJECT_EN
    test_err_inject;
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
